// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command controller: command codes, FSM states
// and the default register file locations of the ALU operands.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR_DEF = 0;
    localparam int OPB_ADDR_DEF = 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OPA      = 4'd5,
        ST_OPB      = 4'd6,
        ST_FUNC     = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_LO    = 4'd9,
        ST_TX_HI    = 4'd10
    } state_t;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Result serializer: presents one or two bytes (LSB first) on a valid/ready
// interface, holding each byte stable until the transmitter accepts it.
module sys_ctrl_tx_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [1:0]              i_count,
    input  logic [2*DATA_WIDTH-1:0] i_word,
    input  logic                    i_tx_ready,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_fire,
    output logic                    o_last
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_hi;
    logic                  r_valid;
    logic [1:0]            r_left;

    assign o_fire     = r_valid & i_tx_ready;
    assign o_last     = (r_left == 2'd1);
    assign o_tx_data  = r_data;
    assign o_tx_valid = r_valid;

    // Load a new result, or step to the next byte on each accepted transfer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_hi    <= '0;
            r_valid <= 1'b0;
            r_left  <= 2'd0;
        end else if (i_load) begin
            r_data  <= i_word[DATA_WIDTH-1:0];
            r_hi    <= i_word[2*DATA_WIDTH-1:DATA_WIDTH];
            r_valid <= (i_count != 2'd0);
            r_left  <= i_count;
        end else if (o_fire) begin
            if (r_left == 2'd2) begin
                r_data <= r_hi;
                r_left <= 2'd1;
            end else begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_left  <= 2'd0;
            end
        end else begin
            r_data  <= r_data;
            r_valid <= r_valid;
        end
    end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Byte-stream command controller: decodes write/read/ALU commands from the
// UART receiver, drives register file and ALU, and returns results via TX.
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUNC_WIDTH    = 4,
    parameter int OPA_ADDR      = OPA_ADDR_DEF,
    parameter int OPB_ADDR      = OPB_ADDR_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DATA_WIDTH-1:0]    i_rx_data,
    input  logic                     i_rx_valid,
    input  logic                     i_rx_err,
    output logic                     o_rf_wr_en,
    output logic                     o_rf_rd_en,
    output logic [ADDR_WIDTH-1:0]    o_rf_addr,
    output logic [DATA_WIDTH-1:0]    o_rf_wr_data,
    input  logic [DATA_WIDTH-1:0]    i_rf_rd_data,
    input  logic                     i_rf_rd_valid,
    output logic                     o_alu_en,
    output logic [FUNC_WIDTH-1:0]    o_alu_func,
    output logic                     o_clk_gate_en,
    input  logic [ALU_OUT_WIDTH-1:0] i_alu_out,
    input  logic                     i_alu_valid,
    output logic [DATA_WIDTH-1:0]    o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_busy,
    output logic                     o_drop
);

    state_t r_state;
    state_t w_state_nxt;

    logic                    r_rf_wr_en, r_rf_rd_en, r_alu_en, r_clk_gate_en, r_drop, r_busy;
    logic [ADDR_WIDTH-1:0]   r_rf_addr, r_addr;
    logic [DATA_WIDTH-1:0]   r_rf_wr_data;
    logic [FUNC_WIDTH-1:0]   r_alu_func, r_func;
    logic                    r_settle;

    logic                    w_rf_wr_en, w_rf_rd_en, w_alu_en, w_clk_gate_en, w_drop, w_settle;
    logic [ADDR_WIDTH-1:0]   w_rf_addr, w_addr;
    logic [DATA_WIDTH-1:0]   w_rf_wr_data;
    logic [FUNC_WIDTH-1:0]   w_alu_func, w_func;
    logic                    w_tx_load;
    logic [1:0]              w_tx_count;
    logic [2*DATA_WIDTH-1:0] w_tx_word;
    logic                    w_tx_fire, w_tx_last;
    logic                    w_rx_ok, w_is_cmd;

    assign w_rx_ok  = i_rx_valid & ~i_rx_err;
    assign w_is_cmd = (i_rx_data == DATA_WIDTH'(CMD_WR))     || (i_rx_data == DATA_WIDTH'(CMD_RD)) ||
                      (i_rx_data == DATA_WIDTH'(CMD_ALU_OP)) || (i_rx_data == DATA_WIDTH'(CMD_ALU_NOP));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; an errored byte aborts any partially received command
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_ok && (i_rx_data == DATA_WIDTH'(CMD_WR)))          w_state_nxt = ST_WR_ADDR;
                else if (w_rx_ok && (i_rx_data == DATA_WIDTH'(CMD_RD)))     w_state_nxt = ST_RD_ADDR;
                else if (w_rx_ok && (i_rx_data == DATA_WIDTH'(CMD_ALU_OP))) w_state_nxt = ST_OPA;
                else if (w_rx_ok && (i_rx_data == DATA_WIDTH'(CMD_ALU_NOP)))w_state_nxt = ST_FUNC;
                else                                                        w_state_nxt = ST_IDLE;
            end
            ST_WR_ADDR: w_state_nxt = i_rx_valid ? (i_rx_err ? ST_IDLE : ST_WR_DATA)  : r_state;
            ST_WR_DATA: w_state_nxt = i_rx_valid ? ST_IDLE : r_state;
            ST_RD_ADDR: w_state_nxt = i_rx_valid ? (i_rx_err ? ST_IDLE : ST_RD_WAIT)  : r_state;
            ST_RD_WAIT: w_state_nxt = i_rf_rd_valid ? ST_TX_LO : r_state;
            ST_OPA:     w_state_nxt = i_rx_valid ? (i_rx_err ? ST_IDLE : ST_OPB)      : r_state;
            ST_OPB:     w_state_nxt = i_rx_valid ? (i_rx_err ? ST_IDLE : ST_FUNC)     : r_state;
            ST_FUNC:    w_state_nxt = i_rx_valid ? (i_rx_err ? ST_IDLE : ST_ALU_WAIT) : r_state;
            ST_ALU_WAIT:w_state_nxt = (i_alu_valid && !r_settle) ? ST_TX_LO : r_state;
            ST_TX_LO:   w_state_nxt = w_tx_fire ? (w_tx_last ? ST_IDLE : ST_TX_HI) : r_state;
            ST_TX_HI:   w_state_nxt = w_tx_fire ? ST_IDLE : r_state;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes and data
    always_comb begin
        w_rf_wr_en    = 1'b0;
        w_rf_rd_en    = 1'b0;
        w_alu_en      = 1'b0;
        w_drop        = 1'b0;
        w_settle      = 1'b0;
        w_rf_addr     = r_rf_addr;
        w_rf_wr_data  = r_rf_wr_data;
        w_alu_func    = r_alu_func;
        w_clk_gate_en = r_clk_gate_en;
        w_addr        = r_addr;
        w_func        = r_func;
        w_tx_load     = 1'b0;
        w_tx_count    = 2'd0;
        w_tx_word     = {{DATA_WIDTH{1'b0}}, i_rf_rd_data};
        case (r_state)
            ST_IDLE:    w_drop = i_rx_valid & (i_rx_err | ~w_is_cmd);
            ST_WR_ADDR: begin
                w_drop = i_rx_valid & i_rx_err;
                w_addr = w_rx_ok ? i_rx_data[ADDR_WIDTH-1:0] : r_addr;
            end
            ST_WR_DATA: begin
                w_drop = i_rx_valid & i_rx_err;
                if (w_rx_ok) begin
                    w_rf_wr_en   = 1'b1;
                    w_rf_addr    = r_addr;
                    w_rf_wr_data = i_rx_data;
                end else begin
                    w_rf_wr_en   = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                w_drop = i_rx_valid & i_rx_err;
                if (w_rx_ok) begin
                    w_rf_rd_en = 1'b1;
                    w_rf_addr  = i_rx_data[ADDR_WIDTH-1:0];
                end else begin
                    w_rf_rd_en = 1'b0;
                end
            end
            ST_OPA, ST_OPB: begin
                w_drop = i_rx_valid & i_rx_err;
                if (w_rx_ok) begin
                    w_rf_wr_en   = 1'b1;
                    w_rf_addr    = (r_state == ST_OPA) ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
                    w_rf_wr_data = i_rx_data;
                end else begin
                    w_rf_wr_en   = 1'b0;
                end
            end
            ST_FUNC: begin
                w_drop = i_rx_valid & i_rx_err;
                if (w_rx_ok) begin
                    w_func        = i_rx_data[FUNC_WIDTH-1:0];
                    w_clk_gate_en = 1'b1;
                    w_settle      = 1'b1;
                end else begin
                    w_settle      = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                w_drop     = i_rx_valid;
                w_tx_load  = i_rf_rd_valid;
                w_tx_count = 2'd1;
            end
            ST_ALU_WAIT: begin
                // Strobe the ALU one cycle after the clock gate opens
                w_drop     = i_rx_valid;
                w_tx_word  = i_alu_out;
                w_tx_count = 2'd2;
                if (r_settle) begin
                    w_alu_en   = 1'b1;
                    w_alu_func = r_func;
                end else if (i_alu_valid) begin
                    w_tx_load     = 1'b1;
                    w_clk_gate_en = 1'b0;
                end else begin
                    w_tx_load     = 1'b0;
                end
            end
            ST_TX_LO, ST_TX_HI: w_drop = i_rx_valid;
            default:            w_drop = 1'b0;
        endcase
    end

    // Registered outputs and command context
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_rf_addr     <= '0;
            r_rf_wr_data  <= '0;
            r_alu_en      <= 1'b0;
            r_alu_func    <= '0;
            r_clk_gate_en <= 1'b0;
            r_drop        <= 1'b0;
            r_busy        <= 1'b0;
            r_addr        <= '0;
            r_func        <= '0;
            r_settle      <= 1'b0;
        end else begin
            r_rf_wr_en    <= w_rf_wr_en;
            r_rf_rd_en    <= w_rf_rd_en;
            r_rf_addr     <= w_rf_addr;
            r_rf_wr_data  <= w_rf_wr_data;
            r_alu_en      <= w_alu_en;
            r_alu_func    <= w_alu_func;
            r_clk_gate_en <= w_clk_gate_en;
            r_drop        <= w_drop;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_addr        <= w_addr;
            r_func        <= w_func;
            r_settle      <= w_settle;
        end
    end

    sys_ctrl_tx_seq #(.DATA_WIDTH(DATA_WIDTH)) u_tx_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tx_load),
        .i_count    (w_tx_count),
        .i_word     (w_tx_word),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_fire     (w_tx_fire),
        .o_last     (w_tx_last)
    );

    assign o_rf_wr_en    = r_rf_wr_en;
    assign o_rf_rd_en    = r_rf_rd_en;
    assign o_rf_addr     = r_rf_addr;
    assign o_rf_wr_data  = r_rf_wr_data;
    assign o_alu_en      = r_alu_en;
    assign o_alu_func    = r_alu_func;
    assign o_clk_gate_en = r_clk_gate_en;
    assign o_drop        = r_drop;
    assign o_busy        = r_busy;

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Command controller in the reference-clock domain, directly downstream of the UART receiver's synchronized byte output.
- Parses the byte-stream command protocol and drives the register file and ALU:
  - 0xAA: write
  - 0xBB: read
  - 0xCC: ALU with operands
  - 0xDD: ALU without operands
- Returns read data and ALU results as bytes to the UART transmitter path using a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, byte width of RX/TX and register file data
- ADDR_WIDTH, 4, register file address width; taken from the LSBs of the address byte
- ALU_OUT_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH
- FUNC_WIDTH, 4, ALU function code width; taken from the LSBs of the function byte
- OPA_ADDR, 0, register file address of ALU operand A
- OPB_ADDR, 1, register file address of ALU operand B

Ports:
- i_clk  in  1  reference clock
- i_rst  in  1  synchronous reset, active-high
- i_rx_data  in  DATA_WIDTH  received byte, already synchronized to i_clk
- i_rx_valid  in  1  single-cycle pulse qualifying i_rx_data
- i_rx_err  in  1  parity or stop error on the current byte; sampled with i_rx_valid
- o_rf_wr_en  out  1  register file write strobe, single cycle
- o_rf_rd_en  out  1  register file read strobe, single cycle
- o_rf_addr  out  ADDR_WIDTH  register file address
- o_rf_wr_data  out  DATA_WIDTH  register file write data
- i_rf_rd_data  in  DATA_WIDTH  register file read data
- i_rf_rd_valid  in  1  read data valid
- o_alu_en  out  1  ALU operation strobe, single cycle
- o_alu_func  out  FUNC_WIDTH  ALU function code
- o_clk_gate_en  out  1  ALU clock-gate enable
- i_alu_out  in  ALU_OUT_WIDTH  ALU result
- i_alu_valid  in  1  ALU result valid
- o_tx_data  out  DATA_WIDTH  byte to the transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts the byte
- o_busy  out  1  high whenever state is not IDLE
- o_drop  out  1  single-cycle pulse when a received byte is discarded

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Internal address and result registers cleared.
  - Reset asserted mid-command aborts the command with no further strobes.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUNC, ALU_WAIT, TX_LO, TX_HI.
- IDLE, on a valid byte:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> OPA
  - 0xDD -> FUNC
  - Any other byte -> stay in IDLE and pulse o_drop.
- Write path:
  - WR_ADDR latches the address, then -> WR_DATA.
  - WR_DATA drives o_rf_wr_en with the latched address and the data byte for one cycle, the cycle after the byte, then -> IDLE.
- Read path:
  - RD_ADDR drives o_rf_rd_en with the address for one cycle, the cycle after the byte, then -> RD_WAIT.
  - RD_WAIT: on i_rf_rd_valid, latch i_rf_rd_data into the low result byte, then -> TX_LO.
  - Read transmits exactly one byte (TX_HI skipped).
- ALU with operands:
  - OPA writes the byte to OPA_ADDR via o_rf_wr_en, then -> OPB.
  - OPB writes the byte to OPB_ADDR via o_rf_wr_en, then -> FUNC.
- FUNC (entered from OPB, or directly from IDLE on 0xDD):
  - o_clk_gate_en rises the cycle after the function byte.
  - o_alu_en and o_alu_func are driven one cycle later (gate settle).
  - Then -> ALU_WAIT.
- ALU_WAIT:
  - On i_alu_valid, latch the full 16-bit result and drop o_clk_gate_en.
  - Then -> TX_LO, then TX_HI.
  - LSB byte is sent first.
- TX_LO / TX_HI:
  - Hold o_tx_valid and o_tx_data stable until the cycle where i_tx_ready=1.
  - The byte is transferred in that cycle.
  - Advance the same cycle.
  - After the last byte -> IDLE.
- i_rx_valid with i_rx_err=1:
  - Byte discarded and o_drop pulsed.
  - Any partially received command is aborted -> IDLE; strobes from already-completed steps are not undone.
- i_rx_valid in RD_WAIT, ALU_WAIT, TX_LO or TX_HI:
  - Byte discarded, o_drop pulsed, state unchanged.
- i_rf_rd_valid or i_alu_valid outside its wait state: ignored.
- Address byte: upper DATA_WIDTH-ADDR_WIDTH bits ignored (0x14 addresses 0x4).
- Function byte: upper bits ignored.
- No bytes are lost when a new valid byte arrives in the same cycle as a single-cycle strobe.

Decomposition:
- Package sys_ctrl_pkg holds:
  - command codes CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD
  - the state enumeration
  - OPA_ADDR and OPB_ADDR defaults
- One natural sub-module, sys_ctrl_tx_seq: the two-byte result serializer with the valid/ready hold logic. The main FSM loads it with a byte count of 1 or 2.

Test Plan:
- Write: bytes 0xAA,0x04,0x8F -> one o_rf_wr_en pulse with addr 0x4 and data 0x8F; no o_tx_valid.
- Read back: bytes 0xBB,0x04, model returns 0x8F -> o_rf_rd_en with addr 0x4, then one TX byte 0x8F; with i_tx_ready held low for 5 cycles, the byte stays stable until accepted.
- ALU with operands: bytes 0xCC,100,50,0x00, model returns 150 -> writes (0x0,100) and (0x1,50), o_alu_en with func 0x0, TX bytes 0x96 then 0x00, o_clk_gate_en low after the result.
- ALU without operands: bytes 0xDD,0x01, model returns 50 -> no register file write, o_alu_en with func 0x1, TX bytes 0x32, 0x00.
- Errors: byte 0x55 in IDLE -> o_drop, stays IDLE; 0xAA,0x05 then a byte with i_rx_err=1 -> no write, IDLE; byte arriving during TX_HI -> o_drop, TX completes intact.
- Reset in ALU_WAIT -> all outputs 0 next cycle; subsequent 0xBB,0x05 sequence works normally.
